mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller between the IF/MEM pipeline stages and the byte-wide unified RAM/IO bus.
- Accepts word-fetch requests from IF and 1/2/4-byte load/store requests from MEM. Requests are arbitrated and serialised into byte accesses.
- Returns assembled little-endian data with a one-cycle finished pulse to the requester.
- MEM holds its request and stalls the pipeline until it sees its finished pulse.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_SEL, 2'b11, value of addr[17:16] that marks the memory-mapped I/O region.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes the block
- if_enable_i  in  1  IF fetch request (level)
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_finished_o  out  1  one-cycle pulse, fetch data valid
- if_inst_o  out  32  fetched word
- mem_enable_i  in  1  MEM request (level)
- mem_addr_i  in  ADDR_WIDTH  load/store address
- mem_len_i  in  3  byte count: 1, 2 or 4
- mem_rw_sel_i  in  1  0 = read, 1 = write
- mem_data_i  in  32  store data
- mem_finished_o  out  1  one-cycle pulse, MEM access complete
- mem_data_o  out  32  load data, zero-extended above the bytes read
- if_busy_o  out  1  high while serving IF
- mem_busy_o  out  1  high while serving MEM
- ram_din  in  8  byte from RAM/IO
- ram_dout  out  8  byte to RAM/IO
- ram_a  out  ADDR_WIDTH  byte address
- ram_wr  out  1  1 = write
- io_buffer_full  in  1  I/O output FIFO full

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE and counters cleared.
  - Every output goes to 0; ram_wr=0 is mandatory.
  - An in-flight transaction is dropped and never resumed.
- rdy low: all registers hold; ram_wr is forced to 0; no finished pulse can occur.
- FSM states and transitions:
  - IDLE: a request is sampled at the edge.
  - READ: cnt increments each cycle.
  - WRITE: cnt increments each cycle.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Arbitration in IDLE:
  - MEM wins over IF when both are enabled in the same cycle.
  - MEM with len not in {1,2,4} is ignored and stays in IDLE.
  - IF requests are always 4-byte reads.
- Capture on accept:
  - addr, len, rw and store data are latched when the request is accepted.
  - Input changes during a transaction are ignored.
- Read timing (request cycle = 0):
  - Cycles 1..N drive ram_a = base+k with ram_wr=0.
  - The byte for the address in cycle c appears on ram_din in cycle c+1 and is stored in bits [8k+7:8k].
  - The requester's finished pulse and data are registered and high in cycle N+2 (DONE).
  - Upper unread bytes of mem_data_o are 0.
- Write timing:
  - Cycles 1..N drive ram_a = base+k, ram_dout = data[8k+7:8k], ram_wr=1.
  - mem_finished_o is high in cycle N+1 (DONE).
- I/O stall:
  - Applies to a write byte whose address has addr[17:16]==IO_SEL while io_buffer_full=1.
  - The controller holds ram_wr=0 and does not advance cnt until io_buffer_full drops.
  - I/O reads are never stalled.
- Busy flags:
  - if_busy_o / mem_busy_o are high from the accept edge through DONE inclusive, for the owner only.
  - They are low in IDLE.
- DONE handling:
  - New requests are not accepted in DONE. A request still high in DONE (requester not yet advanced) is not re-served.
  - The earliest re-accept is in the following IDLE cycle.
- Data outputs: if_inst_o / mem_data_o hold their last value until the next completion of that requester.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44, request in cycle 0 -> ram_a 0x100..0x103 in cycles 1-4; mem_finished_o=1 only in cycle 6; mem_data_o=0x44332211.
- LB at 0x203, byte 0x80 -> mem_data_o=0x00000080; finished in cycle 3; only one ram_a issued.
- SH 0xABCD to 0x30000, io_buffer_full high in cycles 1-3 -> no ram_wr until cycle 4; then 0xCD@0x30000 and 0xAB@0x30001 with ram_wr=1; finished the cycle after the last byte.
- IF 0x0 and MEM LW 0x400 enabled together -> MEM served first (mem_busy_o=1, if_busy_o=0); IF accepted in the IDLE cycle after MEM's DONE; if_inst_o correct.
- rdy low for 3 cycles mid-word-read -> state frozen and ram_wr=0; completion delayed by exactly 3 cycles with correct data.
- rst low during a 4-byte write after byte 1 -> all outputs 0 immediately; no further ram_wr; after release with no request, FSM stays IDLE.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the IF/MEM pipeline stages and mem_ctrl.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  if_enable_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_finished_o;
    logic [31:0]           if_inst_o;
    logic                  mem_enable_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [2:0]            mem_len_i;
    logic                  mem_rw_sel_i;
    logic [31:0]           mem_data_i;
    logic                  mem_finished_o;
    logic [31:0]           mem_data_o;
    logic                  if_busy_o;
    logic                  mem_busy_o;

    // Pipeline side: raises requests, consumes results.
    modport master (
        output if_enable_i, if_addr_i,
        output mem_enable_i, mem_addr_i, mem_len_i, mem_rw_sel_i, mem_data_i,
        input  if_finished_o, if_inst_o, mem_finished_o, mem_data_o,
        input  if_busy_o, mem_busy_o
    );

    // Controller side.
    modport slave (
        input  if_enable_i, if_addr_i,
        input  mem_enable_i, mem_addr_i, mem_len_i, mem_rw_sel_i, mem_data_i,
        output if_finished_o, if_inst_o, mem_finished_o, mem_data_o,
        output if_busy_o, mem_busy_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM/IO bus,
// serialising each request into byte accesses and assembling little-endian results.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    mem_ctrl_if.slave             bus,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic                  owner_mem_q, owner_mem_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic [31:0]           mem_data_q, mem_data_d;
    // Read data returns one cycle after its address; if rdy drops in between, the byte on
    // ram_din is parked here so it is not lost while the block is frozen.
    logic                  stall_q, stall_d;
    logic [7:0]            din_hold_q, din_hold_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           wshift;
    logic [7:0]            byte_in;
    logic [1:0]            rd_idx;
    logic                  io_block;
    logic                  mem_req_ok;

    assign cur_addr   = addr_q + ADDR_WIDTH'(cnt_q);
    assign wshift     = wdata_q >> {cnt_q[1:0], 3'b000};
    assign byte_in    = stall_q ? din_hold_q : ram_din;
    assign rd_idx     = 2'(cnt_q - 3'd1);
    assign io_block   = (cur_addr[17:16] == IO_SEL) && io_buffer_full;
    assign mem_req_ok = bus.mem_enable_i &&
                        (bus.mem_len_i == 3'd1 || bus.mem_len_i == 3'd2 || bus.mem_len_i == 3'd4);

    // Next-state, capture and RAM bus drive; nothing advances while rdy is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        owner_mem_d = owner_mem_q;
        if_inst_d   = if_inst_q;
        mem_data_d  = mem_data_q;
        ram_a       = '0;
        ram_dout    = 8'h00;
        ram_wr      = 1'b0;
        stall_d     = !rdy;
        din_hold_d  = (!rdy && !stall_q) ? ram_din : din_hold_q;

        if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d  = 3'd0;
                    rbuf_d = 32'h0;
                    if (mem_req_ok) begin
                        addr_d      = bus.mem_addr_i;
                        len_d       = bus.mem_len_i;
                        wdata_d     = bus.mem_data_i;
                        owner_mem_d = 1'b1;
                        state_d     = bus.mem_rw_sel_i ? StWrite : StRead;
                    end else if (bus.if_enable_i) begin
                        addr_d      = bus.if_addr_i;
                        len_d       = 3'd4;
                        owner_mem_d = 1'b0;
                        state_d     = StRead;
                    end
                end
                StRead: begin
                    // Address phase for bytes 0..len-1; data for byte k lands one cycle later.
                    if (cnt_q < len_q) begin
                        ram_a = cur_addr;
                    end
                    if (cnt_q != 3'd0) begin
                        rbuf_d = rbuf_q | ({24'h0, byte_in} << {rd_idx, 3'b000});
                    end
                    if (cnt_q == len_q) begin
                        state_d = StDone;
                        if (owner_mem_q) begin
                            mem_data_d = rbuf_d;
                        end else begin
                            if_inst_d = rbuf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StWrite: begin
                    // A full I/O FIFO holds the byte; the bus is parked so nothing is touched.
                    if (!io_block) begin
                        ram_a    = cur_addr;
                        ram_dout = wshift[7:0];
                        ram_wr   = 1'b1;
                        if (cnt_q == len_q - 3'd1) begin
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                StDone: begin
                    cnt_d   = 3'd0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rbuf_q      <= 32'h0;
            owner_mem_q <= 1'b0;
            if_inst_q   <= 32'h0;
            mem_data_q  <= 32'h0;
            stall_q     <= 1'b0;
            din_hold_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            owner_mem_q <= owner_mem_d;
            if_inst_q   <= if_inst_d;
            mem_data_q  <= mem_data_d;
            stall_q     <= stall_d;
            din_hold_q  <= din_hold_d;
        end
    end

    assign bus.if_busy_o      = (state_q != StIdle) && !owner_mem_q;
    assign bus.mem_busy_o     = (state_q != StIdle) && owner_mem_q;
    // DONE is held while frozen, so the pulse is masked until rdy returns.
    assign bus.if_finished_o  = rdy && (state_q == StDone) && !owner_mem_q;
    assign bus.mem_finished_o = rdy && (state_q == StDone) && owner_mem_q;
    assign bus.if_inst_o      = if_inst_q;
    assign bus.mem_data_o     = mem_data_q;
endmodule
